// File: rtl/gf8_pkg.sv
// Shared types and constants for the GF(2^8) Itoh-Tsujii inversion controller.
// Holds the FSM state enum, the hard-wired addition-chain tables for M=8,
// the default reduction polynomial and a 4-bit carry-less multiply helper.
package gf8_pkg;

  localparam int unsigned GF_W      = 8;
  localparam int unsigned PROD_W    = 2 * GF_W - 1;
  localparam int unsigned SQ_W      = 2;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned CHAIN_LEN = 4;

  localparam logic [8:0] POLY_DEFAULT = 9'h11B;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    MUL,
    FSQ,
    DONE
  } state_e;

  // Chain 1-2-3-6-7: squarings before each multiply, and which multiplicand
  // (1 = saved intermediate b_sav, 0 = original operand a_r).
  localparam logic [SQ_W-1:0]      SQ_CNT [CHAIN_LEN] = '{2'd1, 2'd1, 2'd3, 2'd1};
  localparam logic [CHAIN_LEN-1:0] MUL_SEL            = 4'b0100;

  // Carry-less 4x4 multiply, 7-bit product.
  function automatic logic [6:0] clmul4(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ (7'(x) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/itoh_tsujii_inv_ctrl_if.sv
// Handshake bundle for the inversion controller.
// Input side: in_valid/in_ready/a. Output side: out_valid/out_ready/c. busy status.
// slave = controller view, master = operand source / result consumer view.
interface itoh_tsujii_inv_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] c;
  logic       busy;

  modport slave  (input  in_valid, a, out_ready,
                  output in_ready, out_valid, c, busy);
  modport master (output in_valid, a, out_ready,
                  input  in_ready, out_valid, c, busy);
endinterface

// File: rtl/gf8_mul.sv
// Combinational GF(2^8) multiplier: one-level Karatsuba carry-less product
// (15 bits) followed by reduction modulo POLY.
// Ports: x_i, y_i operands; p_o reduced product.
module gf8_mul
  import gf8_pkg::*;
#(
  parameter logic [8:0] POLY = POLY_DEFAULT
) (
  input  logic [GF_W-1:0] x_i,
  input  logic [GF_W-1:0] y_i,
  output logic [GF_W-1:0] p_o
);

  logic [6:0]        hi, lo, mid;
  logic [PROD_W-1:0] prod, red;

  always_comb begin
    hi   = clmul4(x_i[7:4], y_i[7:4]);
    lo   = clmul4(x_i[3:0], y_i[3:0]);
    // Karatsuba middle term: (xh+xl)(yh+yl) - hi - lo, all in GF(2)
    mid  = clmul4(x_i[7:4] ^ x_i[3:0], y_i[7:4] ^ y_i[3:0]) ^ hi ^ lo;
    prod = (PROD_W'(hi) << 8) ^ (PROD_W'(mid) << 4) ^ PROD_W'(lo);
    // Fold high bits down from the top, one polynomial shift per bit
    red  = prod;
    for (int i = PROD_W - 1; i >= GF_W; i--) begin
      if (red[i]) red = red ^ (PROD_W'(POLY) << (i - GF_W));
    end
    p_o  = red[GF_W-1:0];
  end

endmodule

// File: rtl/itoh_tsujii_inv_ctrl.sv
// GF(2^8) inverse controller: a^-1 = a^254 via Itoh-Tsujii chain 1-2-3-6-7
// then one final squaring, sharing a single multiplier one op per cycle.
// Ports: clk, rst (sync, active-high); bus (slave) carries in_valid/in_ready/a,
// out_valid/out_ready/c and busy.
module itoh_tsujii_inv_ctrl
  import gf8_pkg::*;
#(
  parameter logic [8:0]  POLY = POLY_DEFAULT,
  parameter int unsigned M    = GF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  itoh_tsujii_inv_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [M-1:0]      a_r_q, a_r_d;
  logic [M-1:0]      t_q, t_d;
  logic [M-1:0]      b_sav_q, b_sav_d;
  logic [M-1:0]      c_q, c_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [M-1:0]      mul_y, mul_p;
  logic [STEP_W-1:0] step_nxt;

  gf8_mul #(.POLY(POLY)) u_mul (
    .x_i (t_q),
    .y_i (mul_y),
    .p_o (mul_p)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_r_q       <= '0;
      t_q         <= '0;
      b_sav_q     <= '0;
      c_q         <= '0;
      step_q      <= '0;
      sq_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_r_q       <= a_r_d;
      t_q         <= t_d;
      b_sav_q     <= b_sav_d;
      c_q         <= c_d;
      step_q      <= step_d;
      sq_cnt_q    <= sq_cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath mux and registered-output next values
  always_comb begin
    state_d     = state_q;
    a_r_d       = a_r_q;
    t_d         = t_q;
    b_sav_d     = b_sav_q;
    c_d         = c_q;
    step_d      = step_q;
    sq_cnt_d    = sq_cnt_q;
    out_valid_d = out_valid_q;
    step_nxt    = step_q + STEP_W'(1);
    mul_y       = t_q;

    if (state_q == MUL) begin
      mul_y = MUL_SEL[step_q[1:0]] ? b_sav_q : a_r_q;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_r_d    = bus.a;
          t_d      = bus.a;
          b_sav_d  = bus.a;
          step_d   = '0;
          sq_cnt_d = SQ_CNT[0];
          state_d  = SQR;
        end
      end
      SQR: begin
        t_d      = mul_p;
        sq_cnt_d = sq_cnt_q - SQ_W'(1);
        if (sq_cnt_q == SQ_W'(1)) state_d = MUL;
      end
      MUL: begin
        t_d = mul_p;
        // Last chain entry done: t holds a^127, only the final square remains
        if (step_nxt == STEP_W'(CHAIN_LEN)) begin
          state_d = FSQ;
        end else begin
          step_d   = step_nxt;
          sq_cnt_d = SQ_CNT[step_nxt[1:0]];
          b_sav_d  = mul_p;
          state_d  = SQR;
        end
      end
      FSQ: begin
        c_d         = mul_p;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_itoh_tsujii_inv_ctrl.sv
// Self-checking bench for itoh_tsujii_inv_ctrl: directed scenarios, random
// operands with random back-pressure, and a full nonzero sweep, all checked
// against a brute-force GF(2^8) inverse model.
module tb_itoh_tsujii_inv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  itoh_tsujii_inv_ctrl_if bus ();

  itoh_tsujii_inv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Schoolbook shift-and-add multiply mod x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = xx[7] ? ((xx << 1) ^ 8'h1B) : (xx << 1);
    end
    return p;
  endfunction

  // Inverse by exhaustive search; 0 maps to 0
  function automatic logic [7:0] ref_inv(input logic [7:0] x);
    logic [7:0] b;
    if (x == 8'h00) return 8'h00;
    for (int k = 1; k < 256; k++) begin
      b = 8'(k);
      if (gmul(x, b) == 8'h01) return b;
    end
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction, starting and ending at a negedge with the DUT idle.
  // hold = cycles of out_ready=0 after out_valid; poke = drive a second operand then.
  task automatic op(input logic [7:0] av, input int hold, input bit poke);
    int         lat;
    bit         ir_seen;
    logic [7:0] exp_c;
    exp_c = ref_inv(av);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a         = av;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    lat     = 0;
    ir_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ir_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd11);
    chk("in_ready_low_while_busy", 32'(ir_seen), 32'd0);
    chk("c_value", 32'(bus.c), 32'(exp_c));
    if (av != 8'h00) chk("a_times_c", 32'(gmul(av, bus.c)), 32'd1);
    if (hold == 0) begin
      @(negedge clk);
      chk("out_valid_pulse", 32'(bus.out_valid), 32'd0);
    end else begin
      for (int h = 0; h < hold; h++) begin
        if (poke) begin
          bus.in_valid = 1'b1;
          bus.a        = 8'h02;
        end
        @(negedge clk);
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_c", 32'(bus.c), 32'(exp_c));
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("release_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_c", 32'(bus.c), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic inverse and known vectors back-to-back
    op(8'h53, 0, 1'b0);
    chk("vec_53", 32'(bus.c), 32'hCA);
    op(8'h01, 0, 1'b0);
    chk("vec_01", 32'(bus.c), 32'h01);
    op(8'h02, 0, 1'b0);
    chk("vec_02", 32'(bus.c), 32'h8D);
    op(8'hFF, 0, 1'b0);
    chk("vec_ff", 32'(bus.c), 32'h1C);

    // Zero operand
    op(8'h00, 0, 1'b0);

    // Back-pressure with a competing operand that must not be captured
    op(8'h53, 5, 1'b1);
    op(8'h02, 0, 1'b0);
    chk("bp_second", 32'(bus.c), 32'h8D);

    // Reset mid-operation
    bus.a        = 8'h53;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_c", 32'(bus.c), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    op(8'h02, 0, 1'b0);
    chk("midrst_next", 32'(bus.c), 32'h8D);

    // Random operands with random back-pressure
    for (int r = 0; r < 40; r++) begin
      op(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Exhaustive nonzero sweep
    for (int v = 1; v < 256; v++) begin
      op(8'(v), 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
